// File: rtl/frontend_pkg.sv
// rtl/frontend_pkg.sv - shared frontend widths and the instruction buffer entry type
package frontend_pkg;

  localparam int INST_W           = 32;
  localparam int FETCH_LINE_W     = 128;
  localparam int FETCH_SLOTS      = 4;
  localparam int LINE_OFFSET_BITS = 4;
  localparam int PC_W_DEF         = 64;

  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [PC_W_DEF-1:0] pc;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_line_split.sv
// rtl/ibuf_line_split.sv - splits a fetch line into per-slot instruction, PC and valid mask
module ibuf_line_split
  import frontend_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [FETCH_LINE_W-1:0]            i_fetch_line,
  input  logic [PC_W-1:0]                    i_fetch_pc,
  output logic [FETCH_SLOTS-1:0]             o_slot_valid,
  output logic [FETCH_SLOTS-1:0][INST_W-1:0] o_slot_inst,
  output logic [FETCH_SLOTS-1:0][PC_W-1:0]   o_slot_pc,
  output logic [2:0]                         o_slot_cnt
);

  logic [1:0] w_start;
  logic       w_unused_pc_lsb;

  // Slots below the fetch offset belong to instructions before the fetch PC.
  assign w_start         = i_fetch_pc[3:2];
  assign w_unused_pc_lsb = ^i_fetch_pc[1:0];

  // Per-slot valid/instruction/PC and the number of slots kept.
  always_comb begin
    o_slot_valid = '0;
    o_slot_inst  = '0;
    o_slot_pc    = '0;
    for (int k = 0; k < FETCH_SLOTS; k++) begin
      o_slot_valid[k] = (2'(k) >= w_start);
      o_slot_inst[k]  = i_fetch_line[k*INST_W +: INST_W];
      o_slot_pc[k]    = {i_fetch_pc[PC_W-1:LINE_OFFSET_BITS], 2'(k), 2'b00};
    end
    o_slot_cnt = 3'(FETCH_SLOTS) - {1'b0, w_start};
  end

endmodule

// File: rtl/ibuffer.sv
// rtl/ibuffer.sv - instruction buffer between fetch and decode; IBUF_PERF_EN adds perf counters
module ibuffer
  import frontend_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [PC_W-1:0]         boot_addr,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_target,
  input  logic                    fetch_line_valid,
  input  logic [FETCH_LINE_W-1:0] fetch_line,
  input  logic [PC_W-1:0]         fetch_pc,
  output logic                    fetch_inst,
  output logic                    ibuf_inst_valid,
  output logic [INST_W-1:0]       ibuf_inst,
  output logic [PC_W-1:0]         ibuf_pc,
  input  logic                    ibuf_inst_ready
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]             perf_empty_cycles,
  output logic [31:0]             perf_stale_drops
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LINE_W = PC_W - LINE_OFFSET_BITS;
  localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(DEPTH - FETCH_SLOTS);

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t              r_rd_ptr;
  ptr_t              r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [LINE_W-1:0] r_exp_line;
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];

  logic [FETCH_SLOTS-1:0]             w_slot_valid;
  logic [FETCH_SLOTS-1:0][INST_W-1:0] w_slot_inst;
  logic [FETCH_SLOTS-1:0][PC_W-1:0]   w_slot_pc;
  logic [2:0]                         w_slot_cnt;
  logic [1:0]                         w_start;
  logic                               w_line_match;
  logic                               w_accept;
  logic                               w_deq;
  logic [CNT_W-1:0]                   w_add;
  logic [CNT_W-1:0]                   w_sub;
  ptr_t                               w_wr_idx [FETCH_SLOTS];

  ibuf_line_split #(.PC_W(PC_W)) u_line_split (
    .i_fetch_line (fetch_line),
    .i_fetch_pc   (fetch_pc),
    .o_slot_valid (w_slot_valid),
    .o_slot_inst  (w_slot_inst),
    .o_slot_pc    (w_slot_pc),
    .o_slot_cnt   (w_slot_cnt)
  );

  assign w_start         = fetch_pc[3:2];
  assign fetch_inst      = (r_count <= ROOM_MAX);
  assign ibuf_inst_valid = (r_count != '0);
  assign ibuf_inst       = ibuf_inst_valid ? r_inst_mem[r_rd_ptr] : '0;
  assign ibuf_pc         = ibuf_inst_valid ? r_pc_mem[r_rd_ptr] : '0;

  // A full line is taken only when it is the expected one and all of it fits.
  assign w_line_match = (fetch_pc[PC_W-1:LINE_OFFSET_BITS] == r_exp_line);
  assign w_accept     = fetch_line_valid && !redirect_valid && w_line_match && fetch_inst;
  assign w_deq        = ibuf_inst_valid && ibuf_inst_ready && !redirect_valid;
  assign w_add        = w_accept ? CNT_W'(w_slot_cnt) : '0;
  assign w_sub        = w_deq ? CNT_W'(1) : '0;

  // Kept slot k lands k-start entries past the write pointer, wrapping modulo DEPTH.
  always_comb begin
    for (int k = 0; k < FETCH_SLOTS; k++) begin
      w_wr_idx[k] = r_wr_ptr + ptr_t'(k) - ptr_t'(w_start);
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int k = 0; k < FETCH_SLOTS; k++) begin
        if (w_slot_valid[k]) begin
          r_inst_mem[w_wr_idx[k]] <= w_slot_inst[k];
          r_pc_mem[w_wr_idx[k]]   <= w_slot_pc[k];
        end
      end
    end
  end

  // Pointers, occupancy and expected line; redirect overrides any enqueue/dequeue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_exp_line <= boot_addr[PC_W-1:LINE_OFFSET_BITS];
    end else if (redirect_valid) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_exp_line <= redirect_target[PC_W-1:LINE_OFFSET_BITS];
    end else begin
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + ptr_t'(w_slot_cnt);
        r_exp_line <= r_exp_line + LINE_W'(1);
      end
      r_count <= r_count + w_add - w_sub;
    end
  end

`ifdef IBUF_PERF_EN
  logic [31:0] r_perf_empty;
  logic [31:0] r_perf_stale;
  logic        w_stale;

  assign w_stale           = fetch_line_valid && !redirect_valid && !w_line_match;
  assign perf_empty_cycles = r_perf_empty;
  assign perf_stale_drops  = r_perf_stale;

  // Saturating counters for starved cycles and lines lost to a PC mismatch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_empty <= '0;
      r_perf_stale <= '0;
    end else begin
      if (!ibuf_inst_valid && !redirect_valid && (r_perf_empty != '1)) begin
        r_perf_empty <= r_perf_empty + 32'd1;
      end
      if (w_stale && (r_perf_stale != '1)) begin
        r_perf_stale <= r_perf_stale + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ibuffer.sv
// tb/tb_ibuffer.sv - randomized and directed self-checking bench for ibuffer
module tb_ibuffer;

  logic         clock;
  logic         reset_n;
  logic [63:0]  boot_addr;
  logic         redirect_valid;
  logic [63:0]  redirect_target;
  logic         fetch_line_valid;
  logic [127:0] fetch_line;
  logic [63:0]  fetch_pc;
  logic         fetch_inst;
  logic         ibuf_inst_valid;
  logic [31:0]  ibuf_inst;
  logic [63:0]  ibuf_pc;
  logic         ibuf_inst_ready;
`ifdef IBUF_PERF_EN
  logic [31:0]  perf_empty_cycles;
  logic [31:0]  perf_stale_drops;
`endif

  ibuffer #(.DEPTH(8), .PC_W(64)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .boot_addr        (boot_addr),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .fetch_line_valid (fetch_line_valid),
    .fetch_line       (fetch_line),
    .fetch_pc         (fetch_pc),
    .fetch_inst       (fetch_inst),
    .ibuf_inst_valid  (ibuf_inst_valid),
    .ibuf_inst        (ibuf_inst),
    .ibuf_pc          (ibuf_pc),
    .ibuf_inst_ready  (ibuf_inst_ready)
`ifdef IBUF_PERF_EN
    ,
    .perf_empty_cycles(perf_empty_cycles),
    .perf_stale_drops (perf_stale_drops)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: a plain FIFO of {inst, pc} and the expected line number.
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [59:0] m_exp;
  bit          m_room;
  bit          m_take;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_exp = boot_addr >> 4;
    end else if (redirect_valid) begin
      m_q.delete();
      m_exp = redirect_target >> 4;
    end else begin
      m_room = (m_q.size() <= 4);
      m_take = fetch_line_valid && ((fetch_pc >> 4) == m_exp) && m_room;
      if (m_q.size() != 0 && ibuf_inst_ready) void'(m_q.pop_front());
      if (m_take) begin
        for (int k = int'(fetch_pc[3:2]); k < 4; k++) begin
          m_q.push_back('{inst: fetch_line[32*k +: 32], pc: (fetch_pc & ~64'hF) + 64'(4 * k)});
        end
        m_exp = m_exp + 60'd1;
      end
    end
  end

  // Every cycle out of reset, DUT outputs must match the model.
  always @(negedge clock) begin
    if (reset_n) begin
      check("cmp_fetch_inst", 64'(fetch_inst), 64'(m_q.size() <= 4));
      check("cmp_valid", 64'(ibuf_inst_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0 && ibuf_inst_valid) begin
        check("cmp_inst", 64'(ibuf_inst), 64'(m_q[0].inst));
        check("cmp_pc", ibuf_pc, m_q[0].pc);
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send_line(input logic [63:0] pc, input logic [127:0] data);
    fetch_line_valid = 1'b1;
    fetch_pc         = pc;
    fetch_line       = data;
    cycle();
    fetch_line_valid = 1'b0;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] l_d;

  initial begin
    reset_n          = 1'b0;
    boot_addr        = 64'h8000_0000;
    redirect_valid   = 1'b0;
    redirect_target  = '0;
    fetch_line_valid = 1'b0;
    fetch_line       = '0;
    fetch_pc         = '0;
    ibuf_inst_ready  = 1'b0;
    cycle();
    check("rst_valid", 64'(ibuf_inst_valid), 64'd0);
    check("rst_fetch_inst", 64'(fetch_inst), 64'd1);
    check("rst_inst", 64'(ibuf_inst), 64'd0);
    check("rst_pc", ibuf_pc, 64'd0);
    cycle();
    reset_n = 1'b1;

    // Aligned line drains in order with consecutive PCs.
    l_d = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
    ibuf_inst_ready = 1'b1;
    send_line(64'h8000_0000, l_d);
    check("al_inst0", 64'(ibuf_inst), 64'hD0D0_D0D0);
    check("al_pc0", ibuf_pc, 64'h8000_0000);
    check("al_fetch_inst", 64'(fetch_inst), 64'd1);
    cycle();
    check("al_inst1", 64'(ibuf_inst), 64'hD1D1_D1D1);
    check("al_pc1", ibuf_pc, 64'h8000_0004);
    cycle();
    check("al_pc2", ibuf_pc, 64'h8000_0008);
    cycle();
    check("al_inst3", 64'(ibuf_inst), 64'hD3D3_D3D3);
    check("al_pc3", ibuf_pc, 64'h8000_000C);
    cycle();
    check("al_empty", 64'(ibuf_inst_valid), 64'd0);

    // Unaligned start after a redirect keeps only slots 2 and 3.
    ibuf_inst_ready = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 64'h8000_0108;
    cycle();
    redirect_valid = 1'b0;
    l_d = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1, 32'hC0C0_C0C0};
    send_line(64'h8000_0108, l_d);
    check("un_inst", 64'(ibuf_inst), 64'hC2C2_C2C2);
    check("un_pc", ibuf_pc, 64'h8000_0108);
    check("un_model_exp", 64'(m_exp), 64'h0800_0011);
    ibuf_inst_ready = 1'b1;
    cycle();
    check("un_pc3", ibuf_pc, 64'h8000_010C);
    cycle();
    check("un_empty", 64'(ibuf_inst_valid), 64'd0);

    // Backpressure fills the buffer; fetch_inst drops and order is kept.
    ibuf_inst_ready = 1'b0;
    send_line(64'h8000_0110, rand_line());
    send_line(64'h8000_0120, rand_line());
    check("bp_fetch_inst0", 64'(fetch_inst), 64'd0);
    check("bp_head", ibuf_pc, 64'h8000_0110);
    check("bp_model_cnt", 64'(m_q.size()), 64'd8);
    ibuf_inst_ready = 1'b1;
    repeat (4) cycle();
    check("bp_fetch_inst1", 64'(fetch_inst), 64'd1);
    check("bp_head5", ibuf_pc, 64'h8000_0120);

    // Redirect flush wins over a same-cycle line and dequeue.
    ibuf_inst_ready = 1'b0;
    send_line(64'h8000_013C, rand_line());
    check("fl_fetch_inst", 64'(fetch_inst), 64'd0);
    ibuf_inst_ready  = 1'b1;
    redirect_valid   = 1'b1;
    redirect_target  = 64'h2000;
    send_line(64'h8000_0140, rand_line());
    redirect_valid  = 1'b0;
    ibuf_inst_ready = 1'b0;
    check("fl_valid", 64'(ibuf_inst_valid), 64'd0);
    check("fl_fetch_inst1", 64'(fetch_inst), 64'd1);

    // Stale line is dropped, the expected one is taken.
    send_line(64'h1010, rand_line());
    check("st_drop", 64'(ibuf_inst_valid), 64'd0);
    l_d = rand_line();
    send_line(64'h2000, l_d);
    check("st_pc", ibuf_pc, 64'h2000);
    check("st_inst", 64'(ibuf_inst), 64'(l_d[31:0]));
`ifdef IBUF_PERF_EN
    check("st_perf", 64'(perf_stale_drops), 64'd1);
`endif

    // Concurrent enqueue/dequeue at count 4 with the write pointer wrapping.
    send_line(64'h2018, rand_line());
    check("cc_fetch_inst0", 64'(fetch_inst), 64'd0);
    ibuf_inst_ready = 1'b1;
    repeat (2) cycle();
    check("cc_fetch_inst1", 64'(fetch_inst), 64'd1);
    check("cc_head_a", ibuf_pc, 64'h2008);
    send_line(64'h2020, rand_line());
    check("cc_fetch_inst2", 64'(fetch_inst), 64'd0);
    check("cc_head_b", ibuf_pc, 64'h200C);
    check("cc_model_cnt", 64'(m_q.size()), 64'd7);
    repeat (3) cycle();
    check("cc_head_c", ibuf_pc, 64'h2020);
    repeat (2) cycle();
    check("cc_head_wrap", ibuf_pc, 64'h2028);
    repeat (2) cycle();
    check("cc_empty", 64'(ibuf_inst_valid), 64'd0);

    // Async reset in the middle of a cycle clears everything at once.
    ibuf_inst_ready = 1'b0;
    send_line(64'h2030, rand_line());
    boot_addr = 64'h4000;
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", 64'(ibuf_inst_valid), 64'd0);
    check("ar_fetch_inst", 64'(fetch_inst), 64'd1);
    check("ar_pc", ibuf_pc, 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    send_line(64'h4004, rand_line());
    check("ar_boot_pc", ibuf_pc, 64'h4004);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      redirect_valid   = ($urandom_range(0, 19) == 0);
      redirect_target  = {32'h0, $urandom()};
      fetch_line_valid = ($urandom_range(0, 1) == 1);
      fetch_line       = rand_line();
      if ($urandom_range(0, 99) < 85) fetch_pc = {m_exp, 4'($urandom())};
      else                           fetch_pc = {32'h0, $urandom()};
      ibuf_inst_ready  = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
